// File: rtl/key_search_ctrl_pkg.sv
// Shared definitions for the key search controller.
//   KEY_W_DEF            default candidate key width
//   CH_LO_DEF/CH_HI_DEF  default printable byte window
//   ks_state_t           search FSM states
//   scan_ph_t            pt scanner phases
//   is_printable()       byte window test
package key_search_ctrl_pkg;
    localparam int         KEY_W_DEF = 24;
    localparam logic [7:0] CH_LO_DEF = 8'h20;
    localparam logic [7:0] CH_HI_DEF = 8'h7E;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_A4, RD_LEN, CHK, NEXT, DONE
    } ks_state_t;

    typedef enum logic [1:0] {
        SC_IDLE, SC_WAIT, SC_LEN, SC_CHK
    } scan_ph_t;

    function automatic logic is_printable(input logic [7:0] b,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction
endpackage

// File: rtl/key_search_ctrl_pt_scan.sv
// Plaintext scanner: reads the length byte at address 0, then checks bytes
// 1..len against the printable window, one byte per cycle.
//   clk, rst_n   clock / async active-low reset
//   start        pulse: begin a scan (address 0 is presented next cycle)
//   rddata       pt memory read data (1-cycle synchronous latency)
//   addr         pt memory read address
//   len_phase    high during the cycle the length byte is latched
//   done, pass   done pulses once per scan; pass qualifies the verdict
module key_search_ctrl_pt_scan
    import key_search_ctrl_pkg::*;
#(
    parameter logic [7:0] CH_LO = CH_LO_DEF,
    parameter logic [7:0] CH_HI = CH_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] rddata,
    output logic [7:0] addr,
    output logic       len_phase,
    output logic       done,
    output logic       pass
);
    scan_ph_t   ph;
    logic [7:0] len;
    logic [7:0] idx;   // index of the byte currently on rddata
    logic       dvld;  // rddata holds a byte issued in the previous cycle

    assign len_phase = (ph == SC_LEN);

    always_comb begin
        done = 1'b0;
        pass = 1'b0;
        if (ph == SC_LEN && rddata == 8'h00) begin
            // empty message is accepted outright
            done = 1'b1;
            pass = 1'b1;
        end else if (ph == SC_CHK && dvld) begin
            if (!is_printable(rddata, CH_LO, CH_HI)) begin
                done = 1'b1;
            end else if (idx == len) begin
                done = 1'b1;
                pass = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= SC_IDLE;
            addr <= 8'h00;
            len  <= 8'h00;
            idx  <= 8'h00;
            dvld <= 1'b0;
        end else if (start) begin
            addr <= 8'h00;
            dvld <= 1'b0;
            ph   <= SC_WAIT;
        end else begin
            case (ph)
                SC_WAIT: ph <= SC_LEN;
                SC_LEN: begin
                    len <= rddata;
                    if (rddata == 8'h00) begin
                        ph <= SC_IDLE;
                    end else begin
                        addr <= 8'h01;
                        dvld <= 1'b0;
                        ph   <= SC_CHK;
                    end
                end
                SC_CHK: begin
                    if (done) begin
                        dvld <= 1'b0;
                        ph   <= SC_IDLE;
                    end else begin
                        dvld <= 1'b1;
                        idx  <= addr;
                        // stop at len so len=255 never wraps to 0
                        if (addr != len) addr <= addr + 8'h01;
                    end
                end
                default: ph <= SC_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/key_search_ctrl.sv
// Key search controller: sweeps candidate keys through an external arc4,
// then scans the resulting plaintext for all-printable content.
//   clk, rst_n          clock / async active-low reset
//   en, rdy             search start handshake (en honoured while rdy=1)
//   key, key_valid      search result, valid while rdy=1
//   a4_en, a4_rdy       arc4 start pulse / arc4 ready
//   a4_key              candidate key, stable while arc4 runs
//   pt_addr, pt_rddata  pt memory read port
//   pt_owner            1 = this block drives the pt memory port
module key_search_ctrl
    import key_search_ctrl_pkg::*;
#(
    parameter int               KEY_W     = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY_START = '0,
    parameter logic [KEY_W-1:0] KEY_MAX   = '1,
    parameter logic [7:0]       CH_LO     = CH_LO_DEF,
    parameter logic [7:0]       CH_HI     = CH_HI_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             a4_en,
    input  logic             a4_rdy,
    output logic [KEY_W-1:0] a4_key,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic             pt_owner
);
    ks_state_t        state, state_n;
    logic [KEY_W-1:0] a4_key_n, key_n;
    logic             key_valid_n, pt_owner_n;
    logic             accept, accept_n;
    logic             first, first_n;  // first WAIT_A4 cycle: arc4 rdy not yet dropped
    logic             scan_start, scan_len, scan_done, scan_pass;

    key_search_ctrl_pt_scan #(.CH_LO(CH_LO), .CH_HI(CH_HI)) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (scan_start),
        .rddata    (pt_rddata),
        .addr      (pt_addr),
        .len_phase (scan_len),
        .done      (scan_done),
        .pass      (scan_pass)
    );

    always_comb begin
        state_n     = state;
        a4_key_n    = a4_key;
        key_n       = key;
        key_valid_n = key_valid;
        pt_owner_n  = pt_owner;
        accept_n    = accept;
        first_n     = first;
        a4_en       = 1'b0;
        scan_start  = 1'b0;
        case (state)
            IDLE: begin
                if (en && rdy) begin
                    key_valid_n = 1'b0;
                    a4_key_n    = KEY_START;
                    accept_n    = 1'b0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                // decoded from state, so reset forces it low immediately
                if (a4_rdy) begin
                    a4_en   = 1'b1;
                    first_n = 1'b1;
                    state_n = WAIT_A4;
                end
            end
            WAIT_A4: begin
                first_n = 1'b0;
                if (!first && a4_rdy) begin
                    pt_owner_n = 1'b1;
                    scan_start = 1'b1;
                    state_n    = RD_LEN;
                end
            end
            RD_LEN: begin
                if (scan_done) begin
                    accept_n = 1'b1;
                    state_n  = DONE;
                end else if (scan_len) begin
                    state_n = CHK;
                end
            end
            CHK: begin
                if (scan_done) begin
                    accept_n = scan_pass;
                    state_n  = scan_pass ? DONE : NEXT;
                end
            end
            NEXT: begin
                pt_owner_n = 1'b0;
                // >= also ends a sweep whose start lies above its limit
                if (a4_key >= KEY_MAX) begin
                    key_valid_n = 1'b0;
                    accept_n    = 1'b0;
                    state_n     = DONE;
                end else begin
                    a4_key_n = a4_key + 1'b1;
                    state_n  = ISSUE;
                end
            end
            DONE: begin
                pt_owner_n = 1'b0;
                if (accept) begin
                    key_n       = a4_key;
                    key_valid_n = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            a4_key    <= '0;
            pt_owner  <= 1'b0;
            accept    <= 1'b0;
            first     <= 1'b0;
        end else begin
            state     <= state_n;
            rdy       <= (state_n == IDLE);
            key       <= key_n;
            key_valid <= key_valid_n;
            a4_key    <= a4_key_n;
            pt_owner  <= pt_owner_n;
            accept    <= accept_n;
            first     <= first_n;
        end
    end
endmodule
